// File: rtl/gray_updown_counter_if.sv
// Control and status bundle for gray_updown_counter: count/load controls in,
// registered Gray/binary count and flags out.
interface gray_updown_counter_if #(
    parameter int WIDTH = 4
) ();
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_gray;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] bin_q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, load, load_gray,
        input  gray_q, bin_q, tc, wrap
    );

    modport slave (
        input  en, up_dn, load, load_gray,
        output gray_q, bin_q, tc, wrap
    );
endinterface

// File: rtl/gray_updown_counter.sv
// Up/down counter holding its state in binary, with Gray and binary outputs
// registered on the same edge, Gray parallel load, wrap/saturate ends and flags.
module gray_updown_counter #(
    parameter int          WIDTH    = 4,
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned RST_BIN  = 32'd0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gray_updown_counter_if.slave   bus
);

    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RST_B    = RST_BIN[WIDTH-1:0];

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_q;
    logic             wrap_d;

    // Next-state: load beats count, count beats hold; ends wrap or saturate.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            bin_d = gray2bin(bus.load_gray);
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (bin_q == ALL_ONES) begin
                    if (SATURATE) begin
                        bin_d = bin_q;
                    end else begin
                        bin_d  = ZERO;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q + ONE;
                end
            end else begin
                if (bin_q == ZERO) begin
                    if (SATURATE) begin
                        bin_d = bin_q;
                    end else begin
                        bin_d  = ALL_ONES;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q - ONE;
                end
            end
        end else begin
            bin_d = bin_q;
        end
        // Gray is derived from the next binary so both outputs land on one edge.
        gray_d = bin2gray(bin_d);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= RST_B;
            gray_q <= bin2gray(RST_B);
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.bin_q  = bin_q;
    assign bus.gray_q = gray_q;
    assign bus.wrap   = wrap_q;
    assign bus.tc     = bus.up_dn ? (bin_q == ALL_ONES) : (bin_q == ZERO);

endmodule

// File: tb/tb_gray_updown_counter.sv
// Scoreboard bench: a wrapping and a saturating 4-bit instance share clock and
// reset; directed steps push expected values, a negedge monitor compares them.
module tb_gray_updown_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    gray_updown_counter_if #(.WIDTH(4)) if0 ();
    gray_updown_counter_if #(.WIDTH(4)) if1 ();

    gray_updown_counter #(.WIDTH(4), .SATURATE(1'b0), .RST_BIN(32'd0)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    gray_updown_counter #(.WIDTH(4), .SATURATE(1'b1), .RST_BIN(32'd0)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        bit         dut;
        logic [3:0] bin;
        logic [3:0] gray;
        logic       wrap;
        bit         single;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [3:0] prev_gray [2];
    logic [3:0] a_bin, a_gray, e_tc_v;
    logic       a_wrap, a_tc, cur_up;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %b want %b", nm, cyc, act, exp);
        end
    endtask

    // Monitor: pops every expectation due this cycle and compares it.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stale_entry: due %0d seen %0d", e.due, cyc);
            end
            a_bin  = e.dut ? if1.bin_q  : if0.bin_q;
            a_gray = e.dut ? if1.gray_q : if0.gray_q;
            a_wrap = e.dut ? if1.wrap   : if0.wrap;
            a_tc   = e.dut ? if1.tc     : if0.tc;
            cur_up = e.dut ? if1.up_dn  : if0.up_dn;
            e_tc_v = {3'b000, (cur_up ? (e.bin == 4'b1111) : (e.bin == 4'b0000))};
            chk(e.dut ? "sat_bin"  : "wrap_bin",  a_bin,  e.bin);
            chk(e.dut ? "sat_gray" : "wrap_gray", a_gray, e.gray);
            chk(e.dut ? "sat_wrap" : "wrap_wrap", {3'b000, a_wrap}, {3'b000, e.wrap});
            chk(e.dut ? "sat_tc"   : "wrap_tc",   {3'b000, a_tc}, e_tc_v);
            chk("gray_eq_bin", a_gray, a_bin ^ (a_bin >> 1));
            if (e.single) begin
                chk("single_bit", 4'($countones(a_gray ^ prev_gray[e.dut])), 4'd1);
            end
            prev_gray[e.dut] = a_gray;
        end
    end

    // One clock of stimulus on instance d; the other instance idles.
    task automatic drive(input bit d, input logic rn, input logic en, input logic up,
                         input logic ld, input logic [3:0] lg,
                         input logic [3:0] eb, input logic [3:0] eg,
                         input logic ew, input bit single);
        @(posedge clk);
        #1;
        rst_n         = rn;
        if0.en        = (d == 1'b0) ? en : 1'b0;
        if0.up_dn     = (d == 1'b0) ? up : 1'b1;
        if0.load      = (d == 1'b0) ? ld : 1'b0;
        if0.load_gray = (d == 1'b0) ? lg : 4'b0000;
        if1.en        = (d == 1'b1) ? en : 1'b0;
        if1.up_dn     = (d == 1'b1) ? up : 1'b1;
        if1.load      = (d == 1'b1) ? ld : 1'b0;
        if1.load_gray = (d == 1'b1) ? lg : 4'b0000;
        sb.push_back('{due: cyc + 1, dut: d, bin: eb, gray: eg, wrap: ew, single: single});
        if (rn == 1'b0) begin
            sb.push_back('{due: cyc + 1, dut: ~d, bin: 4'b0000, gray: 4'b0000, wrap: 1'b0, single: 1'b0});
        end
    endtask

    initial begin
        logic [3:0] gtab [16];
        gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        prev_gray[0] = 4'b0000;
        prev_gray[1] = 4'b0000;
        if0.en = 1'b0; if0.up_dn = 1'b1; if0.load = 1'b0; if0.load_gray = 4'b0000;
        if1.en = 1'b0; if1.up_dn = 1'b1; if1.load = 1'b0; if1.load_gray = 4'b0000;

        // Reset for two clocks
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Up sweep: 16 steps, wrap only on 1111 -> 0000
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'(k), gtab[k % 16], (k == 16), 1'b1);
        end

        // Reset in the middle of a count
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0101, 4'b0110, 4'b0101, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Down through zero with tc, then wrap to 1111
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b1000, 1'b1, 1'b1);

        // Load wins over enable
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1101, 4'b1001, 4'b1101, 1'b0, 1'b0);

        // Direction flips, then hold
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0111, 4'b0101, 4'b0111, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0110, 4'b0101, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0101, 4'b0111, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0110, 4'b0101, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0110, 4'b0101, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0110, 4'b0101, 1'b0, 1'b0);

        // Saturating instance: hold at 1111 going up, at 0000 going down
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 4'b1111, 4'b1000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1000, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Drain the scoreboard within a bounded number of cycles
        for (int w = 0; w < 10 && sb.size() > 0; w++) begin
            @(negedge clk);
        end
        #1;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
